// File: rtl/sd_pkg.sv
// sd_pkg: shared SD-bus constants, command-transmit state encoding and the CRC7 step function.
package sd_pkg;
  localparam int SD_CMD_FRAME_BITS = 48;
  localparam int SD_CMD_PAYLOAD_BITS = 40;
  localparam logic [6:0] SD_CRC7_POLY = 7'h09;
  typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, STOP, NCC} sd_cmd_state_t;
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    return {crc[5:0], 1'b0} ^ ((b ^ crc[6]) ? SD_CRC7_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/sd_crc7_ser.sv
// sd_crc7_ser: serial CRC7 (x^7+x^3+1); clear and enable together fold bit_i into a fresh zero CRC.
module sd_crc7_ser
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) crc_o <= '0;
    else if (en_i) crc_o <= crc7_step(clr_i ? 7'h00 : crc_o, bit_i);
    else if (clr_i) crc_o <= '0;
endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serialises one 48-bit SD command frame onto CMD, advancing on clken_i ticks.
// Optional trailing NCC idle-high ticks are enabled by defining SD_CMD_TX_NCC_EN.
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int NCC_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clken_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] arg_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [5:0] PAYLOAD_LAST = 6'(SD_CMD_PAYLOAD_BITS - 1);
  localparam logic [5:0] CRC_LAST = 6'(SD_CMD_FRAME_BITS - SD_CMD_PAYLOAD_BITS - 2);
  localparam logic [5:0] NCC_LAST = 6'(NCC_CYCLES - 1);
  sd_cmd_state_t r_state;
  logic [39:0] r_sr;
  logic [5:0]  r_cnt;
  logic        r_cmd, r_oe, r_busy, r_done;
  logic        w_accept, w_crc_en, w_crc_bit, w_last;
  logic [6:0]  w_crc;
  assign w_accept = (r_state == IDLE) && start_i;
  assign w_last = (r_cnt == 6'd0);
  assign w_crc_en = w_accept || ((r_state == PAYLOAD) && clken_i && !w_last);
  assign w_crc_bit = w_accept ? 1'b0 : r_sr[39];
  sd_crc7_ser u_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_accept),
    .en_i  (w_crc_en),
    .bit_i (w_crc_bit),
    .crc_o (w_crc)
  );
  // r_sr holds the bits still to launch; at the end of payload it is reloaded with the CRC tail and end bit
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_cnt <= '0;
      r_cmd <= 1'b1;
      r_oe <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start_i) begin
          r_sr <= {1'b1, cmd_idx_i, arg_i, 1'b0};
          r_cmd <= 1'b0;
          r_oe <= 1'b1;
          r_busy <= 1'b1;
          r_cnt <= PAYLOAD_LAST;
          r_state <= PAYLOAD;
        end
        PAYLOAD: if (clken_i) begin
          r_cmd <= w_last ? w_crc[6] : r_sr[39];
          r_sr <= w_last ? {w_crc[5:0], 1'b1, 33'd0} : {r_sr[38:0], 1'b0};
          r_cnt <= w_last ? CRC_LAST : r_cnt - 6'd1;
          if (w_last) r_state <= CRC;
        end
        CRC: if (clken_i) begin
          r_cmd <= r_sr[39];
          r_sr <= {r_sr[38:0], 1'b0};
          r_cnt <= w_last ? NCC_LAST : r_cnt - 6'd1;
          if (w_last) r_state <= STOP;
        end
        STOP: if (clken_i) begin
`ifdef SD_CMD_TX_NCC_EN
          r_state <= NCC;
`else
          r_state <= IDLE;
          r_oe <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
`endif
        end
`ifdef SD_CMD_TX_NCC_EN
        NCC: if (clken_i) begin
          if (w_last) begin
            r_state <= IDLE;
            r_oe <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else r_cnt <= r_cnt - 6'd1;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  assign cmd_o = r_cmd;
  assign cmd_oe_o = r_oe;
  assign busy_o = r_busy;
  assign done_o = r_done;
endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: table-driven frames checked through a scoreboard of expected serial frames.
module tb_sd_cmd_tx;
`ifdef SD_CMD_TX_NCC_EN
  localparam int NCC = 8;
`else
  localparam int NCC = 0;
`endif
  localparam int NB = 48 + NCC;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clken_i = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  cmd_idx_i = '0;
  logic [31:0] arg_i = '0;
  logic        cmd_o, cmd_oe_o, busy_o, done_o;
  int total = 0;
  int bad = 0;
  logic stall = 1'b0;
  int div = 0;
  logic [63:0] sb[$];
  logic [63:0] rx = '0;
  int nbits = 0;
  int n_done = 0;
  logic done_prev = 1'b0;
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
  } vec_t;
  vec_t vt[7];
  sd_cmd_tx #(.NCC_CYCLES(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clken_i  (clken_i),
    .start_i  (start_i),
    .cmd_idx_i(cmd_idx_i),
    .arg_i    (arg_i),
    .cmd_o    (cmd_o),
    .cmd_oe_o (cmd_oe_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [47:0] model(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] d;
    logic [6:0] c;
    logic fb;
    d = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {d, c, 1'b1};
  endfunction
  function automatic logic [63:0] ext(input logic [47:0] f);
    logic [63:0] e;
    e = {16'd0, f};
    for (int i = 0; i < NCC; i++) e = {e[62:0], 1'b1};
    return e;
  endfunction
  initial forever begin
    @(posedge clk_i);
    #1;
    div++;
    clken_i = !stall && (div % 4 == 0);
  end
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      rx = '0;
      nbits = 0;
    end else begin
      if (done_prev) chk("done_width", 64'(done_o), 64'd0);
      if (done_o) begin
        chk("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          chk("frame", rx, sb.pop_front());
          chk("ticks", 64'(nbits), 64'(NB));
          chk("oe_after", 64'(cmd_oe_o), 64'd0);
        end
        rx = '0;
        nbits = 0;
        n_done++;
      end
      if (clken_i && cmd_oe_o) begin
        rx = {rx[62:0], cmd_o};
        nbits++;
      end
    end
    done_prev = done_o;
  end
  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy_o; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk("idle_wait", 64'(busy_o), 64'd0);
  endtask
  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && n_done < target; i++) @(posedge clk_i);
    #1;
    chk("done_count", 64'(n_done), 64'(target));
  endtask
  task automatic wait_bits(input int n);
    for (int i = 0; i < 3000 && nbits < n; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk("bits_reached", 64'(nbits >= n), 64'd1);
  endtask
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] f);
    wait_idle();
    start_i = 1'b1;
    cmd_idx_i = idx;
    arg_i = arg;
    sb.push_back(ext(f));
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask
  initial begin
    int nd;
    int changes;
    int n0;
    logic hold;
    nd = 0;
    vt[0] = '{6'd0, 32'h0, 48'h400000000095};
    vt[1] = '{6'd17, 32'h0, 48'h510000000055};
    vt[2] = '{6'd8, 32'h1AA, 48'h48000001AA87};
    vt[3] = '{6'd55, 32'h0, 48'h770000000065};
    vt[4] = '{6'd41, 32'h40000000, 48'h694000000077};
    for (int i = 5; i < 7; i++) begin
      vt[i].idx = 6'($urandom_range(0, 63));
      vt[i].arg = $urandom;
      vt[i].frame = model(vt[i].idx, vt[i].arg);
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cmd", 64'(cmd_o), 64'd1);
    chk("rst_oe", 64'(cmd_oe_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 7; i++) begin
      send(vt[i].idx, vt[i].arg, vt[i].frame);
      chk("accept_busy", 64'(busy_o), 64'd1);
      nd++;
      wait_done(nd);
    end
    send(6'd0, 32'h0, vt[0].frame);
    wait_bits(20);
    rst_i = 1'b1;
    #1;
    chk("midrst_cmd", 64'(cmd_o), 64'd1);
    chk("midrst_oe", 64'(cmd_oe_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    void'(sb.pop_back());
    @(posedge clk_i);
    #1;
    chk("midrst_busy_clk", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    send(6'd17, 32'h0, vt[1].frame);
    nd++;
    wait_done(nd);
    wait_idle();
    start_i = 1'b1;
    cmd_idx_i = 6'd0;
    arg_i = 32'h0;
    sb.push_back(ext(vt[0].frame));
    @(posedge clk_i);
    #1;
    cmd_idx_i = 6'd17;
    sb.push_back(ext(vt[1].frame));
    nd++;
    wait_done(nd);
    start_i = 1'b0;
    chk("b2b_busy", 64'(busy_o), 64'd1);
    chk("b2b_start_bit", 64'(cmd_o), 64'd0);
    nd++;
    wait_done(nd);
    send(6'd8, 32'h1AA, vt[2].frame);
    wait_bits(42);
    stall = 1'b1;
    @(posedge clk_i);
    #2;
    hold = cmd_o;
    n0 = nbits;
    changes = 0;
    repeat (100) begin
      @(posedge clk_i);
      #2;
      if (cmd_o !== hold) changes++;
    end
    chk("stall_cmd_changes", 64'(changes), 64'd0);
    chk("stall_bits", 64'(nbits), 64'(n0));
    stall = 1'b0;
    nd++;
    wait_done(nd);
    repeat (10) @(posedge clk_i);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
